dsp_mac_sequencer: RTL and testbench

DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

---
 rtl/dsp_seq_pkg.sv | 27 ++
 rtl/dsp_seq_token_pipe.sv | 25 ++
 rtl/dsp_mac_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_seq_pkg.sv
// Shared FSM encoding and DSP48A1 OPMODE constants for the MAC sequencer.
package dsp_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // X = M, Z = P; bit 7 turns Z + X into Z - X.
  localparam logic [7:0] OPM_IDLE    = 8'h00;
  localparam logic [7:0] OPM_MAC_ADD = 8'h09;
  localparam logic [7:0] OPM_MAC_SUB = 8'h89;

  function automatic logic [7:0] opmode_for(input logic sub);
    logic [7:0] opm;
    if (sub) begin
      opm = OPM_MAC_SUB;
    end else begin
      opm = OPM_MAC_ADD;
    end
    return opm;
  endfunction

endpackage

// File: rtl/dsp_seq_token_pipe.sv
// Two-stage token pipeline tracking which beats are in the DSP M and P stages.
module dsp_seq_token_pipe (
  input  logic clk,
  input  logic rst_n,
  input  logic fire,
  input  logic flush,
  output logic t1,
  output logic t2
);

  // Shift accepted-beat tokens alongside the DSP register stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t1 <= 1'b0;
      t2 <= 1'b0;
    end else if (flush) begin
      t1 <= 1'b0;
      t2 <= 1'b0;
    end else begin
      t1 <= fire;
      t2 <= t1;
    end
  end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences an operand stream through a DSP48A1 (A1/B1, M, P registered) as a
// clear-then-accumulate MAC job and hands the final P back on a handshake.
module dsp_mac_sequencer #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             RST_N,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  input  logic             SUB,
  input  logic             ABORT,
  output logic             BUSY,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [17:0]      IN_A,
  input  logic [17:0]      IN_B,
  output logic [17:0]      DSP_A,
  output logic [17:0]      DSP_B,
  output logic             DSP_CEA,
  output logic             DSP_CEB,
  output logic             DSP_CEM,
  output logic             DSP_CEP,
  output logic             DSP_RSTP,
  output logic [7:0]       DSP_OPMODE,
  input  logic [47:0]      DSP_P,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [47:0]      OUT_DATA
);
  import dsp_seq_pkg::*;

  state_t             state_r;
  state_t             next_state_s;
  logic [LEN_W-1:0]   len_r;
  logic               sub_r;
  logic [LEN_W-1:0]   cnt_r;
  logic [LEN_W-1:0]   cnt_inc_s;
  logic               busy_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               rstp_r;
  logic [7:0]         opmode_r;
  logic [47:0]        out_data_r;
  logic               fire_s;
  logic               abort_s;
  logic               last_beat_s;
  logic               sub_sel_s;
  logic               t1_s;
  logic               t2_s;

  assign fire_s      = IN_VALID & in_ready_r;
  assign abort_s     = ABORT & (state_r != ST_IDLE);
  assign cnt_inc_s   = cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
  assign last_beat_s = fire_s & (cnt_inc_s == len_r);

  dsp_seq_token_pipe u_token_pipe (
    .clk   (clk),
    .rst_n (RST_N),
    .fire  (fire_s),
    .flush (abort_s),
    .t1    (t1_s),
    .t2    (t2_s)
  );

  // SUB is taken straight from the port on the START cycle, before it is latched.
  always_comb begin
    sub_sel_s = sub_r;
    if (state_r == ST_IDLE) begin
      sub_sel_s = SUB;
    end else begin
      sub_sel_s = sub_r;
    end
  end

  // Next-state decode; ABORT overrides every other transition.
  always_comb begin
    next_state_s = state_r;
    if (abort_s) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (START) begin
            next_state_s = (LEN == {LEN_W{1'b0}}) ? ST_DONE : ST_CLEAR;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_CLEAR:  next_state_s = ST_STREAM;
        ST_STREAM: begin
          if (last_beat_s) begin
            next_state_s = ST_DRAIN;
          end else begin
            next_state_s = ST_STREAM;
          end
        end
        ST_DRAIN: begin
          if (!t1_s && !t2_s) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_DRAIN;
          end
        end
        ST_DONE: begin
          if (OUT_READY) begin
            next_state_s = ST_IDLE;
          end else begin
            next_state_s = ST_DONE;
          end
        end
        default: next_state_s = ST_IDLE;
      endcase
    end
  end

  // State register and job parameter latch.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
      len_r   <= {LEN_W{1'b0}};
      sub_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (state_r == ST_IDLE && START) begin
        len_r <= LEN;
        sub_r <= SUB;
      end
    end
  end

  // Accepted-beat counter, only live while streaming.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      cnt_r <= {LEN_W{1'b0}};
    end else if (abort_s || state_r != ST_STREAM) begin
      cnt_r <= {LEN_W{1'b0}};
    end else if (fire_s) begin
      cnt_r <= cnt_inc_s;
    end
  end

  // Registered control outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      busy_r      <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      rstp_r      <= 1'b0;
      opmode_r    <= OPM_IDLE;
    end else begin
      busy_r      <= (next_state_s != ST_IDLE);
      in_ready_r  <= (next_state_s == ST_STREAM);
      out_valid_r <= (next_state_s == ST_DONE);
      rstp_r      <= abort_s | (next_state_s == ST_CLEAR);
      if (next_state_s == ST_CLEAR || next_state_s == ST_STREAM ||
          next_state_s == ST_DRAIN) begin
        opmode_r <= opmode_for(sub_sel_s);
      end else begin
        opmode_r <= OPM_IDLE;
      end
    end
  end

  // Result capture: zero for an empty job, otherwise P once the pipe is empty.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      out_data_r <= 48'h0;
    end else if (state_r == ST_IDLE && next_state_s == ST_DONE) begin
      out_data_r <= 48'h0;
    end else if (state_r == ST_DRAIN && next_state_s == ST_DONE) begin
      out_data_r <= DSP_P;
    end
  end

  // Operands are gated to zero whenever no beat can be accepted.
  assign DSP_A      = in_ready_r ? IN_A : 18'h0;
  assign DSP_B      = in_ready_r ? IN_B : 18'h0;
  assign DSP_CEA    = fire_s;
  assign DSP_CEB    = fire_s;
  assign DSP_CEM    = t1_s;
  assign DSP_CEP    = t2_s;
  assign DSP_RSTP   = rstp_r;
  assign DSP_OPMODE = opmode_r;
  assign BUSY       = busy_r;
  assign IN_READY   = in_ready_r;
  assign OUT_VALID  = out_valid_r;
  assign OUT_DATA   = out_data_r;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: drives jobs into the sequencer wired to a
// DSP48A1 behavioural model and checks results against a sum-of-products model.
module tb_dsp_mac_sequencer;

  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             RST_N;
  logic             START;
  logic [LEN_W-1:0] LEN;
  logic             SUB;
  logic             ABORT;
  logic             BUSY;
  logic             IN_VALID;
  logic             IN_READY;
  logic [17:0]      IN_A;
  logic [17:0]      IN_B;
  logic [17:0]      DSP_A;
  logic [17:0]      DSP_B;
  logic             DSP_CEA;
  logic             DSP_CEB;
  logic             DSP_CEM;
  logic             DSP_CEP;
  logic             DSP_RSTP;
  logic [7:0]       DSP_OPMODE;
  logic [47:0]      DSP_P;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [47:0]      OUT_DATA;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic signed [17:0] op_a [16];
  logic signed [17:0] op_b [16];

  dsp_mac_sequencer #(.LEN_W(LEN_W)) dut (
    .clk        (clk),
    .RST_N      (RST_N),
    .START      (START),
    .LEN        (LEN),
    .SUB        (SUB),
    .ABORT      (ABORT),
    .BUSY       (BUSY),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .IN_A       (IN_A),
    .IN_B       (IN_B),
    .DSP_A      (DSP_A),
    .DSP_B      (DSP_B),
    .DSP_CEA    (DSP_CEA),
    .DSP_CEB    (DSP_CEB),
    .DSP_CEM    (DSP_CEM),
    .DSP_CEP    (DSP_CEP),
    .DSP_RSTP   (DSP_RSTP),
    .DSP_OPMODE (DSP_OPMODE),
    .DSP_P      (DSP_P),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_DATA   (OUT_DATA)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // DSP48A1 model: A1/B1, M, P and OPMODE registered, CEOPMODE=1, sync RSTP,
  // carry-in from OPMODE[5]; the C port is not used and reads as zero.
  logic signed [17:0] a1_r = 18'sd0;
  logic signed [17:0] b1_r = 18'sd0;
  logic signed [35:0] m_r  = 36'sd0;
  logic [47:0]        p_r  = 48'h0;
  logic [7:0]         opm_r = 8'h00;
  logic [47:0]        x_s;
  logic [47:0]        z_s;

  always_comb begin
    case (opm_r[1:0])
      2'b01:   x_s = {{12{m_r[35]}}, m_r};
      2'b10:   x_s = p_r;
      default: x_s = 48'h0;
    endcase
    z_s = opm_r[3] ? p_r : 48'h0;
  end

  always @(posedge clk) begin
    opm_r <= DSP_OPMODE;
    if (DSP_CEA) a1_r <= DSP_A;
    if (DSP_CEB) b1_r <= DSP_B;
    if (DSP_CEM) m_r <= a1_r * b1_r;
    if (DSP_RSTP) p_r <= 48'h0;
    else if (DSP_CEP) begin
      if (opm_r[7]) p_r <= z_s - (x_s + {47'h0, opm_r[5]});
      else          p_r <= z_s + x_s + {47'h0, opm_r[5]};
    end
  end

  assign DSP_P = p_r;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One job: expected result is the signed sum of the products (negated for SUB).
  task automatic run_job(input int len, input bit sub, input int stall_pct,
                         input int gap, input int hold);
    longint      exp_acc;
    logic [47:0] exp_p;
    int idx, v_cyc, last_fire, t0, gap_left;
    int n_cea, n_cem, n_cep, n_rdy, n_rstp;
    bit got, opm_taken;
    logic [7:0] opm_seen;

    exp_acc = 0;
    for (int i = 0; i < len; i++)
      exp_acc += (sub ? -64'sd1 : 64'sd1) * (longint'(op_a[i]) * longint'(op_b[i]));
    exp_p = exp_acc[47:0];

    idx = 0; v_cyc = 0; last_fire = -1; gap_left = 0; got = 0; opm_taken = 0;
    n_cea = 0; n_cem = 0; n_cep = 0; n_rdy = 0; n_rstp = 0; opm_seen = 8'h00;

    @(posedge clk); #1;
    t0 = cyc;
    START = 1'b1; LEN = LEN_W'(len); SUB = sub;
    for (int c = 0; c < 300 && !got; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        START = 1'b0;
      end
      if (idx < len && gap_left == 0 && $urandom_range(99) >= stall_pct) begin
        IN_VALID = 1'b1; IN_A = op_a[idx]; IN_B = op_b[idx];
      end else begin
        IN_VALID = 1'b0; IN_A = 18'($urandom); IN_B = 18'($urandom);
      end
      if (gap_left > 0) gap_left--;
      @(negedge clk);
      if (DSP_CEA) n_cea++;
      if (DSP_CEM) n_cem++;
      if (DSP_CEP) n_cep++;
      if (IN_READY) n_rdy++;
      if (DSP_RSTP) n_rstp++;
      if (IN_READY && !opm_taken) begin
        opm_seen = DSP_OPMODE; opm_taken = 1;
      end
      if (IN_VALID && IN_READY) begin
        check("dsp_a_follow", {DSP_A, DSP_B}, {IN_A, IN_B});
        idx++;
        last_fire = cyc - t0;
        if (idx == 1) gap_left = gap;
      end
      if (OUT_VALID) begin
        got = 1; v_cyc = cyc - t0;
      end
    end
    IN_VALID = 1'b0;
    START = 1'b0;
    if (!got) begin
      check("job_timeout", 64'd0, 64'd1);
      return;
    end

    check("out_data", OUT_DATA, exp_p);
    if (len == 0) begin
      check("lat_len0", v_cyc, 1);
      check("in_ready_len0", n_rdy, 0);
      check("cea_len0", n_cea, 0);
    end else begin
      check("beats_taken", idx, len);
      check("lat_after_last", v_cyc, last_fire + 4);
      if (stall_pct == 0 && gap == 0) check("lat_nostall", v_cyc, len + 5);
      check("cea_pulses", n_cea, len);
      check("cem_pulses", n_cem, len);
      check("cep_pulses", n_cep, len);
      check("rstp_pulses", n_rstp, 1);
      check("opmode_stream", opm_seen, sub ? 8'h89 : 8'h09);
    end

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      START = 1'b1; LEN = LEN_W'($urandom_range(12, 1));
      @(negedge clk);
      check("hold_valid", OUT_VALID, 1'b1);
      check("hold_data", OUT_DATA, exp_p);
    end
    @(posedge clk); #1;
    OUT_READY = 1'b1;
    @(negedge clk);
    check("handshake_valid", OUT_VALID, 1'b1);
    @(posedge clk); #1;
    OUT_READY = 1'b0; START = 1'b0;
    @(negedge clk);
    check("idle_busy", BUSY, 1'b0);
    check("idle_valid", OUT_VALID, 1'b0);
    check("idle_opmode", DSP_OPMODE, 8'h00);
  endtask

  // Start a 4-beat job, feed 2 beats, then cancel by ABORT or by reset.
  task automatic run_cancel(input bit use_reset);
    int n_valid, n_rstp;
    @(posedge clk); #1;
    START = 1'b1; LEN = 8'd4; SUB = 1'b0; IN_VALID = 1'b1; IN_A = 18'd11; IN_B = 18'd13;
    @(posedge clk); #1;
    START = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    IN_A = 18'd5; IN_B = 18'd9;
    @(posedge clk); #1;
    if (!use_reset) begin
      IN_VALID = 1'b0; ABORT = 1'b1;
      @(negedge clk);
      check("abort_busy_before", BUSY, 1'b1);
      @(posedge clk); #1;
      ABORT = 1'b0;
      @(negedge clk);
      check("abort_busy", BUSY, 1'b0);
      check("abort_rstp", DSP_RSTP, 1'b1);
      check("abort_valid", OUT_VALID, 1'b0);
      check("abort_ready", IN_READY, 1'b0);
      check("abort_opmode", DSP_OPMODE, 8'h00);
      check("abort_tokens", {DSP_CEM, DSP_CEP}, 2'b00);
      n_valid = 0; n_rstp = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        @(negedge clk);
        if (OUT_VALID) n_valid++;
        if (DSP_RSTP || DSP_CEP || DSP_CEM) n_rstp++;
      end
      check("abort_no_valid", n_valid, 0);
      check("abort_quiet", n_rstp, 0);
    end else begin
      IN_A = 18'h1234; IN_B = 18'h0abc;
      #2;
      RST_N = 1'b0;
      #1;
      check("rst_ctrl", {BUSY, IN_READY, DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEP,
                          DSP_RSTP, DSP_OPMODE, OUT_VALID}, 16'h0000);
      check("rst_operands", {DSP_A, DSP_B}, 36'h0);
      check("rst_out_data", OUT_DATA, 48'h0);
      @(negedge clk);
      RST_N = 1'b1; IN_VALID = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("post_rst_busy", BUSY, 1'b0);
    end
    op_a[0] = 18'sd7; op_b[0] = 18'sd8;
    run_job(1, 1'b0, 0, 0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; START = 1'b0; LEN = '0; SUB = 1'b0; ABORT = 1'b0;
    IN_VALID = 1'b0; IN_A = 18'h0; IN_B = 18'h0; OUT_READY = 1'b0;
    #12;
    check("reset_ctrl", {BUSY, IN_READY, DSP_RSTP, OUT_VALID, DSP_CEA, DSP_CEM, DSP_CEP}, 7'h00);
    check("reset_opmode", DSP_OPMODE, 8'h00);
    check("reset_out_data", OUT_DATA, 48'h0);
    @(negedge clk);
    RST_N = 1'b1;

    op_a[0] = 18'sd2; op_b[0] = 18'sd3;
    op_a[1] = 18'sd4; op_b[1] = 18'sd5;
    op_a[2] = 18'sd6; op_b[2] = 18'sd7;
    run_job(3, 1'b0, 0, 0, 0);

    op_a[0] = 18'sd100; op_b[0] = 18'sd100;
    op_a[1] = 18'sd1;   op_b[1] = 18'sd1;
    run_job(2, 1'b0, 0, 3, 0);

    op_a[0] = 18'sd10; op_b[0] = 18'sd10;
    op_a[1] = 18'sd3;  op_b[1] = 18'sd3;
    run_job(2, 1'b1, 0, 0, 0);

    run_job(0, 1'b0, 0, 0, 0);

    op_a[0] = 18'sd123; op_b[0] = -18'sd45;
    op_a[1] = 18'sd77;  op_b[1] = 18'sd2;
    run_job(2, 1'b0, 0, 0, 5);

    run_cancel(1'b0);
    run_cancel(1'b1);

    for (int j = 0; j < 20; j++) begin
      int len;
      len = $urandom_range(12, 1);
      for (int i = 0; i < len; i++) begin
        op_a[i] = 18'($urandom);
        op_b[i] = 18'($urandom);
      end
      run_job(len, 1'($urandom), (j < 5) ? 0 : $urandom_range(50, 0), 0, $urandom_range(3, 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
